// File: rtl/loop_frame_assembler.sv
// Serial-to-parallel frame assembler feeding loop_block_multi: fills an N-word bank, then issues it
// as a held parallel frame with a one-cycle en_out, rate-limited to PERIOD. Optional flush input: LOOP_FRAME_FLUSH_EN.
module loop_frame_assembler #(
    parameter int N      = 19,
    parameter int W      = 16,
    parameter int PERIOD = 150
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
`ifdef LOOP_FRAME_FLUSH_EN
    input  logic                flush,
`endif
    output logic signed [W-1:0] frame_out [N-1:0],
    output logic                en_out,
    output logic                overrun
);

    localparam int IW = $clog2(N + 1);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_WAIT,
        S_ISSUE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                en_q, en_d;
    logic                overrun_q, overrun_d;
    logic signed [W-1:0] fill_q  [N-1:0];
    logic signed [W-1:0] fill_d  [N-1:0];
    logic signed [W-1:0] frame_q [N-1:0];
    logic signed [W-1:0] frame_d [N-1:0];

    logic          xfer;
    logic          last_word;
    logic          ready_to_issue;
    logic          flush_go;
    logic [IW-1:0] pad_start;

    assign s_ready        = (state_q == S_FILL) && (idx_q < IW'(N));
    assign xfer           = s_valid && s_ready;
    assign last_word      = xfer && (idx_q == IW'(N - 1));
    assign ready_to_issue = (cnt_q == '0);

`ifdef LOOP_FRAME_FLUSH_EN
    // A sample arriving with flush is kept, so padding begins just after it.
    assign flush_go  = flush && (state_q == S_FILL) && (idx_q != '0);
    assign pad_start = xfer ? idx_q + IW'(1) : idx_q;
`else
    assign flush_go  = 1'b0;
    assign pad_start = IW'(N);
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            assign fill_d[gi]  = (xfer && (idx_q == IW'(gi)))          ? s_data :
                                 (flush_go && (IW'(gi) >= pad_start))  ? '0     :
                                                                         fill_q[gi];
            assign frame_d[gi] = (state_q == S_ISSUE) ? fill_q[gi] : frame_q[gi];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        en_d      = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            S_FILL: begin
                if (xfer) begin
                    idx_d = idx_q + IW'(1);
                end
                if (last_word || flush_go) begin
                    state_d = S_WAIT;
                    if (cnt_d != '0) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // The timer restarts as the issue begins so that back-to-back en_out
                // pulses land exactly PERIOD cycles apart.
                if (ready_to_issue) begin
                    state_d = S_ISSUE;
                    cnt_d   = CW'(PERIOD - 1);
                end
            end
            S_ISSUE: begin
                en_d    = 1'b1;
                idx_d   = '0;
                state_d = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FILL;
            idx_q     <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                fill_q[i]  <= '0;
                frame_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < N; i++) begin
                fill_q[i]  <= fill_d[i];
                frame_q[i] <= frame_d[i];
            end
        end
    end

    assign frame_out = frame_q;
    assign en_out    = en_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_loop_frame_assembler.sv
// Randomised bench for loop_frame_assembler: a queue-based model collects accepted samples into
// frames and checks every en_out pulse, frame hold, spacing and the directed scenarios.
module tb_loop_frame_assembler;

    localparam int N      = 19;
    localparam int W      = 16;
    localparam int PERIOD = 150;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [W-1:0] s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] frame_out [N-1:0];
    logic                en_out;
    logic                overrun;
`ifdef LOOP_FRAME_FLUSH_EN
    logic                flush = 1'b0;
`endif

    loop_frame_assembler #(.N(N), .W(W), .PERIOD(PERIOD)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
`ifdef LOOP_FRAME_FLUSH_EN
        .flush     (flush),
`endif
        .frame_out (frame_out),
        .en_out    (en_out),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int pulse_count  = 0;
    int pulse_cyc    = 0;
    int prev_pulse_cyc = 0;
    int accept_cyc   = 0;
    int base;
    bit has_prev     = 1'b0;
    bit last_xfer    = 1'b0;

    logic signed [W-1:0] partial   [$];
    logic signed [W-1:0] exp_words [$];
    logic signed [W-1:0] held      [N];

    int t1 [N] = '{0, 0, -8, 8, -8, 8, -8, 0, 16, -24, 16, 0, -16, 0, 0, 0, 0, 0, 0};
    int t6 [5] = '{1, 4, 7, -5, -3};

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe at the falling edge, update the model, return just after the rising edge.
    task automatic tick();
        int  mism;
        bit  flush_eff;
        logic signed [W-1:0] w;
        @(negedge clk);
        if (en_out) begin
            pulse_count++;
            prev_pulse_cyc = pulse_cyc;
            pulse_cyc      = cyc;
            if (has_prev) check("pulse_spacing_min", 32'(pulse_cyc - prev_pulse_cyc >= PERIOD), 1);
            has_prev = 1'b1;
            if (exp_words.size() < N) begin
                check("frame_available", exp_words.size(), N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    w = exp_words.pop_front();
                    check("frame_word", frame_out[i], w);
                    held[i] = w;
                end
            end
            $display("[TB] en_out pulse %0d at cycle %0d, frame_out[0]=%0d", pulse_count, cyc, frame_out[0]);
        end else begin
            mism = 0;
            for (int i = 0; i < N; i++) if (frame_out[i] !== held[i]) mism++;
            check("frame_hold", mism, 0);
        end
        last_xfer = 1'b0;
        flush_eff = 1'b0;
`ifdef LOOP_FRAME_FLUSH_EN
        flush_eff = flush && (partial.size() > 0);
`endif
        if (reset) begin
            partial.delete();
            exp_words.delete();
            has_prev = 1'b0;
            for (int i = 0; i < N; i++) held[i] = '0;
        end else begin
            if (s_valid && s_ready) begin
                last_xfer  = 1'b1;
                accept_cyc = cyc + 1;
                partial.push_back(s_data);
            end
            if (flush_eff && partial.size() > 0) begin
                while (partial.size() < N) partial.push_back('0);
            end
            if (partial.size() == N) begin
                for (int i = 0; i < N; i++) exp_words.push_back(partial[i]);
                partial.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int v, input int pct);
        bit done = 1'b0;
        for (int g = 0; g < 1000 && !done; g++) begin
            s_valid = ($urandom_range(0, 99) < pct);
            s_data  = s_valid ? W'(v) : W'($urandom);
            tick();
            done = last_xfer;
        end
        s_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic wait_pulses(input int target, input int budget);
        for (int i = 0; i < budget && pulse_count < target; i++) tick();
        check("pulse_wait", pulse_count, target);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        int nz = 0;
        for (int i = 0; i < N; i++) if (frame_out[i] !== '0) nz++;
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_en_out"}, en_out, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_frame_zero"}, nz, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) held[i] = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_state("rst0");

        // Directed frame from reset: issue two cycles after the last accept.
        base = pulse_count;
        for (int i = 0; i < N; i++) send(t1[i], 100);
        wait_pulses(base + 1, 50);
        check("t1_latency", pulse_cyc - accept_cyc, 2);
        check("t1_word9", frame_out[9], -24);
        check("t1_word8", frame_out[8], 16);
        check("t1_overrun", overrun, 0);

        // Two frames back-to-back: second one waits on the period timer.
        do_reset();
        base = pulse_count;
        for (int i = 0; i < 2 * N; i++) send(int'($urandom_range(0, 65535)) - 32768, 100);
        wait_pulses(base + 2, 400);
        check("t2_spacing", pulse_cyc - prev_pulse_cyc, PERIOD);
        check("t2_overrun", overrun, 1);

        // Random valid gaps over three frames of 1..57.
        do_reset();
        base = pulse_count;
        for (int v = 1; v <= 3 * N; v++) send(v, 50);
        wait_pulses(base + 3, 400);
        check("t3_first", frame_out[0], 39);
        check("t3_last", frame_out[N-1], 57);
        check("t3_model_empty", exp_words.size(), 0);
        check("t3_overrun", overrun, 1);

        // Reset in the middle of a fill; the new frame is not delayed by the timer.
        for (int i = 0; i < 10; i++) send(1000 + i, 100);
        do_reset();
        check_reset_state("rst_mid");
        base = pulse_count;
        for (int i = 0; i < N; i++) send(-100 - i, 100);
        wait_pulses(base + 1, 50);
        check("t4_latency", pulse_cyc - accept_cyc, 2);
        check("t4_first", frame_out[0], -100);
        repeat (5) tick();
        check("t4_single_pulse", pulse_count, base + 1);

        // Idle with s_valid low: nothing issues, frame_out holds.
        base = pulse_count;
        s_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            s_data = W'($urandom);
            tick();
        end
        check("t5_no_pulse", pulse_count, base);
        check("t5_hold_last", frame_out[N-1], -118);

`ifdef LOOP_FRAME_FLUSH_EN
        // Short frame closed by flush, zero padded.
        base = pulse_count;
        for (int i = 0; i < 5; i++) send(t6[i], 100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_pulses(base + 1, 300);
        check("t6_word3", frame_out[3], -5);
        check("t6_word5", frame_out[5], 0);
        check("t6_word18", frame_out[N-1], 0);
        repeat (200) tick();
        check("t6_single_pulse", pulse_count, base + 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
